// File: rtl/titan_wb_pkg.sv
// Shared Wishbone definitions for the titan instruction and data slaves:
// bus widths, slave FSM state encoding and the address-check helper.
package titan_wb_pkg;

  localparam int WB_ADR_W  = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // True when adr is word aligned and lands inside the window of
  // depth_words words starting at base. The subtraction is unsigned 32-bit,
  // so an address below base wraps to a huge offset and fails the range test.
  function automatic logic wb_addr_ok(input logic [WB_ADR_W-1:0] adr,
                                      input logic [WB_ADR_W-1:0] base,
                                      input logic [WB_ADR_W-1:0] depth_words);
    logic [WB_ADR_W-1:0] offset;
    offset = adr - base;
    return (adr[1:0] == 2'b00) && ((offset >> 2) < depth_words);
  endfunction

endpackage

// File: rtl/wb_imem_slave_if.sv
// Wishbone classic bus bundle between the fetch unit (master) and the
// instruction memory slave. Signal names keep the slave-side _i/_o suffixes.
interface wb_imem_slave_if;
  import titan_wb_pkg::*;

  logic [WB_ADR_W-1:0]  wb_adr_i;
  logic [WB_DATA_W-1:0] wb_dat_i;
  logic [WB_SEL_W-1:0]  wb_sel_i;
  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic                 wb_we_i;
  logic [WB_DATA_W-1:0] wb_dat_o;
  logic                 wb_ack_o;
  logic                 wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

endinterface

// File: rtl/wb_imem_array.sv
// Word array behind the instruction slave: byte-enable write port and a read
// data register that only loads when rd_en is high.
module wb_imem_array
  import titan_wb_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WB_DATA_W-1:0]         wr_data,
  input  logic [WB_SEL_W-1:0]          wr_sel,
  output logic [WB_DATA_W-1:0]         rd_data
);

  logic [WB_DATA_W-1:0] mem [DEPTH_WORDS];
  logic [WB_DATA_W-1:0] rd_data_q;
  logic [WB_DATA_W-1:0] rd_data_d;

  // Byte-lane write: only lanes with their select bit set are replaced.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WB_SEL_W; i++) begin
        if (wr_sel[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read data holds its last value unless a read is being completed.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[idx];
  end

  // Read data register; cleared by reset, array contents are not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/wb_imem_slave.sv
// Wishbone classic-cycle instruction memory slave with programmable wait
// states and err termination for misaligned, out-of-range or illegal
// accesses. Define IMEM_WRITE_EN to allow byte-lane writes; without it the
// array is read-only and every write request ends in err.
module wb_imem_slave
  import titan_wb_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input logic            clk,
  input logic            rst,
  wb_imem_slave_if.slave wb
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

`ifdef IMEM_WRITE_EN
  localparam logic WRITE_ALLOWED = 1'b1;
`else
  localparam logic WRITE_ALLOWED = 1'b0;
`endif

  wb_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WB_DATA_W-1:0] wdata_q, wdata_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic                 we_q, we_d;
  logic                 bad_q, bad_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 wr_en;
  logic                 rd_en;
  logic [WB_DATA_W-1:0] rd_data;

  // Next-state logic: accept in IDLE, count wait states, terminate in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    bad_d   = bad_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          idx_d   = IDX_W'((wb.wb_adr_i - BASE_ADDR) >> 2);
          wdata_d = wb.wb_dat_i;
          sel_d   = wb.wb_sel_i;
          we_d    = wb.wb_we_i;
          bad_d   = !wb_addr_ok(wb.wb_adr_i, BASE_ADDR, 32'(DEPTH_WORDS)) ||
                    (wb.wb_we_i && !WRITE_ALLOWED);
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!wb.wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (wb.wb_cyc_i) begin
          if (bad_q) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            wr_en = we_q;
            rd_en = !we_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered bus outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  wb_imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .idx    (idx_q),
    .wr_data(wdata_q),
    .wr_sel (sel_q),
    .rd_data(rd_data)
  );

  assign wb.wb_dat_o = rd_data;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;

endmodule

// File: tb/tb_wb_imem_slave.sv
// Bench for wb_imem_slave: directed corner cases followed by random fetches,
// scored against a word-level memory model through an expectation queue.
module tb_wb_imem_slave;
  import titan_wb_pkg::*;

  localparam int          DEPTH = 64;
  localparam int          IW    = $clog2(DEPTH);
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WS    = 2;

`ifdef IMEM_WRITE_EN
  localparam bit WRITE_ALLOWED = 1'b1;
`else
  localparam bit WRITE_ALLOWED = 1'b0;
`endif

  typedef struct packed {
    logic        isErr;
    logic [31:0] data;
    logic [31:0] dueEdge;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks    = 0;
  int errors    = 0;
  int edgeCnt   = 0;
  int respSeen  = 0;

  logic [31:0] refMem [DEPTH];
  logic [31:0] refData = 32'h0;
  resp_t       expQ[$];

  wb_imem_slave_if wb();

  wb_imem_slave #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_STATES(WS),
    .INIT_FILE  ("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb (wb)
  );

  // Free-running clock and an edge counter used to time responses.
  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Hard stop in case something escapes the per-transfer bounds.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time %0t reached, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: decides the outcome of one request from the address
  // map rules and updates the model memory, then queues the expected reply.
  task automatic predict(input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                         input logic [3:0] sel, input int acceptEdge);
    resp_t       r;
    logic [31:0] diff;
    logic [31:0] mask;
    logic [IW-1:0] wi;
    bit          bad;
    diff = adr - BASE;
    bad  = (adr % 32'd4 != 32'd0) || (diff / 32'd4 >= 32'(DEPTH)) || (we && !WRITE_ALLOWED);
    wi   = IW'(diff / 32'd4);
    r.isErr   = bad;
    r.dueEdge = 32'(acceptEdge + 1 + WS);
    if (!bad && we) begin
      mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      refMem[wi] = (refMem[wi] & ~mask) | (wdat & mask);
    end else if (!bad) begin
      refData = refMem[wi];
    end
    r.data = refData;
    expQ.push_back(r);
  endtask

  task automatic driveBus(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                          input logic [3:0] sel, input bit cyc, input bit stb);
    wb.wb_adr_i = adr;
    wb.wb_we_i  = we;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = sel;
    wb.wb_cyc_i = cyc;
    wb.wb_stb_i = stb;
  endtask

  task automatic idleBus(input int n);
    driveBus(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  // One classic-cycle transfer, issued at a negedge while the slave is idle
  // (or in its ack cycle). Returns at the negedge showing ack/err with stb
  // still high so the caller can chain a back-to-back request.
  task automatic applyStimulus(input logic [31:0] adr, input bit we,
                               input logic [31:0] dat, input logic [3:0] sel);
    int budget;
    driveBus(adr, we, dat, sel, 1'b1, 1'b1);
    predict(adr, we, dat, sel, edgeCnt + 1);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(wb.wb_ack_o || wb.wb_err_o) && budget < 40);
    checkOutput("respArrived", 32'(wb.wb_ack_o | wb.wb_err_o), 32'd1);
  endtask

  // Monitor: every ack/err seen away from the clock edge is matched
  // against the oldest queued expectation.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst && (wb.wb_ack_o || wb.wb_err_o)) begin
        respSeen++;
        checkOutput("ackErrExclusive", 32'(wb.wb_ack_o & wb.wb_err_o), 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResponse", 32'(wb.wb_err_o), 32'hFFFF_FFFF);
        end else begin
          r = expQ.pop_front();
          checkOutput("respKind", 32'(wb.wb_err_o), 32'(r.isErr));
          checkOutput("respData", wb.wb_dat_o, r.data);
          checkOutput("respEdge", 32'(edgeCnt), r.dueEdge);
        end
      end
    end
  end

  initial begin
    int saved;
    logic [31:0] adr;
    logic [31:0] off;
    int kind;

    driveBus(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      refMem[i] = $urandom;
      if (i == 0) refMem[i] = 32'h1111_1111;
      if (i == 1) refMem[i] = 32'h2364_7862;
      dut.u_array.mem[IW'(i)] <= refMem[i];
    end

    // Reset held for five cycles, then released away from the edge.
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("resetAck", 32'(wb.wb_ack_o), 32'd0);
    checkOutput("resetErr", 32'(wb.wb_err_o), 32'd0);
    checkOutput("resetDat", wb.wb_dat_o, 32'd0);

    // First fetches, then three back-to-back with stb held.
    applyStimulus(BASE, 1'b0, 32'h0, 4'hF);
    idleBus(1);
    applyStimulus(BASE + 32'd4, 1'b0, 32'h0, 4'h0);
    applyStimulus(BASE, 1'b0, 32'h0, 4'h0);
    applyStimulus(BASE + 32'd4, 1'b0, 32'h0, 4'h0);
    applyStimulus(BASE + 32'd8, 1'b0, 32'h0, 4'h0);
    idleBus(1);

    // Misaligned, one past the end, and just below the base.
    applyStimulus(BASE + 32'd2, 1'b0, 32'h0, 4'hF);
    idleBus(1);
    applyStimulus(BASE + 32'(4 * DEPTH), 1'b0, 32'h0, 4'hF);
    idleBus(1);
    applyStimulus(BASE - 32'd4, 1'b0, 32'h0, 4'hF);
    idleBus(1);

    // strobe without cycle must be ignored.
    saved = respSeen;
    driveBus(BASE, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("stbWithoutCyc", 32'(respSeen), 32'(saved));
    idleBus(1);

    // Drop cyc one cycle into the wait: nothing may come back.
    saved = respSeen;
    driveBus(BASE + 32'd4, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    idleBus(6);
    checkOutput("abortNoResponse", 32'(respSeen), 32'(saved));
    applyStimulus(BASE + 32'd4, 1'b0, 32'h0, 4'hF);
    idleBus(1);

    // Partial write then read back of the same word.
    applyStimulus(BASE + 32'd8, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    idleBus(1);
    applyStimulus(BASE + 32'd8, 1'b0, 32'h0, 4'hF);
    idleBus(1);

    // Asynchronous reset in the middle of the wait states.
    driveBus(BASE + 32'd12, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midResetAck", 32'(wb.wb_ack_o), 32'd0);
    checkOutput("midResetErr", 32'(wb.wb_err_o), 32'd0);
    checkOutput("midResetDat", wb.wb_dat_o, 32'd0);
    refData = 32'h0;
    idleBus(3);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(BASE + 32'd4, 1'b0, 32'h0, 4'hF);
    idleBus(1);

    // Random mix of legal and illegal reads and writes.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      off  = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      case (kind)
        0:       adr = BASE + off + 32'($urandom_range(1, 3));
        1:       adr = BASE + 32'(4 * DEPTH) + off;
        2:       adr = BASE - 32'd4 - off;
        default: adr = BASE + off;
      endcase
      applyStimulus(adr, ($urandom_range(0, 3) == 0), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) idleBus($urandom_range(1, 3));
    end
    idleBus(8);

    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
